// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
//
// Scans a 4x4 active-low matrix keypad one row at a time, debounces the
// full-scan result, emits one event per accepted key press, and assembles
// two decimal digits into an x/y coordinate confirmed with '#'.
//
// Ports:
//   i_clk          system clock (10 MHz)
//   i_reset        synchronous, active-high reset
//   i_enable       keyboard mode; gates coordinate entry only
//   i_col_n[3:0]   keypad columns, active low, asynchronous
//   o_row_n[3:0]   keypad row drives, active low, one-hot-low
//   o_key_code[3:0] code of the last accepted key
//   o_key_valid    one-cycle pulse per accepted key press
//   o_x[3:0]       committed x-coordinate (0-9)
//   o_y[3:0]       committed y-coordinate (0-9)
//   o_coord_valid  one-cycle pulse when x/y are committed
//   o_entry_state[1:0] coordinate-entry state (00 X, 01 Y, 10 confirm)
// -----------------------------------------------------------------------------
module keypad_scanner #(
   parameter int SCAN_DIV       = 10000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_enable,
   input  logic [3:0] i_col_n,
   output logic [3:0] o_row_n,
   output logic [3:0] o_key_code,
   output logic       o_key_valid,
   output logic [3:0] o_x,
   output logic [3:0] o_y,
   output logic       o_coord_valid,
   output logic [1:0] o_entry_state
);

   localparam int CNT_W   = $clog2(SCAN_DIV);
   localparam int MATCH_W = $clog2(DEBOUNCE_SCANS + 1);

   // Scan results carry a 5th value: bit 4 set means "no single key".
   localparam logic [4:0] NONE     = 5'h10;
   localparam logic [3:0] KEY_STAR = 4'hE;
   localparam logic [3:0] KEY_HASH = 4'hF;

   typedef enum logic [1:0] {
      WAIT_X    = 2'b00,
      WAIT_Y    = 2'b01,
      WAIT_CONF = 2'b10,
      WAIT_BAD  = 2'b11
   } entry_state_t;

   function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
      logic [3:0] code;
      case ({row, col})
         4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
         4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
         4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
         4'hC: code = 4'hE;  4'hD: code = 4'h0;  4'hE: code = 4'hF;  default: code = 4'hD;
      endcase
      return code;
   endfunction

   // ---------------------------------------------------------------- registers
   logic [3:0]         r_col_meta;
   logic [3:0]         r_col_sync;
   logic [CNT_W-1:0]   r_slot_cnt;
   logic [3:0]         r_row_n;
   logic [1:0]         r_row_idx;
   logic [1:0]         r_acc_cnt;   // keys seen so far this scan, saturates at 2
   logic [3:0]         r_acc_code;
   logic [4:0]         r_cand;
   logic [4:0]         r_stable;
   logic [MATCH_W-1:0] r_match;
   logic [3:0]         r_key_code;
   logic               r_key_valid;
   entry_state_t       r_state;
   logic [3:0]         r_x_pend;
   logic [3:0]         r_y_pend;
   logic [3:0]         r_x;
   logic [3:0]         r_y;
   logic               r_coord_valid;

   // -------------------------------------------------------------------- wires
   logic               w_slot_end;
   logic               w_scan_end;
   logic [3:0]         w_col_low;
   logic [2:0]         w_row_cnt;
   logic [3:0]         w_row_code;
   logic [2:0]         w_sum;
   logic [1:0]         w_tot_cnt;
   logic [3:0]         w_tot_code;
   logic [4:0]         w_scan_result;
   logic [4:0]         w_cand_next;
   logic [MATCH_W-1:0] w_match_next;
   logic               w_accept;
   entry_state_t       w_state_next;
   logic [3:0]         w_x_pend_next;
   logic [3:0]         w_y_pend_next;
   logic               w_commit;

   assign w_slot_end = (r_slot_cnt == CNT_W'(SCAN_DIV - 1));
   assign w_scan_end = w_slot_end && (r_row_idx == 2'd3);
   assign w_col_low  = ~r_col_sync;

   // Count low columns on the current row and remember the key code; the
   // code is only meaningful when exactly one column is low.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      w_row_cnt  = 3'd0;
      w_row_code = 4'h0;
      for (int c = 0; c < 4; c++) begin
         if (w_col_low[c]) begin
            w_row_cnt  = w_row_cnt + 3'd1;
            w_row_code = key_map(r_row_idx, 2'(c));
         end
      end
   end

   // Merge this row into the running scan tally (0, 1 or "2+ keys").
   assign w_sum         = {1'b0, r_acc_cnt} + w_row_cnt;
   assign w_tot_cnt     = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
   assign w_tot_code    = (r_acc_cnt == 2'd0) ? w_row_code : r_acc_code;
   assign w_scan_result = (w_tot_cnt == 2'd1) ? {1'b0, w_tot_code} : NONE;

   // Debounce: count consecutive identical scans, saturating.
   always_comb begin
      if (w_scan_result == r_cand) begin
         w_cand_next  = r_cand;
         w_match_next = (r_match == MATCH_W'(DEBOUNCE_SCANS)) ? r_match
                                                               : r_match + MATCH_W'(1);
      end else begin
         w_cand_next  = w_scan_result;
         w_match_next = MATCH_W'(1);
      end
   end

   assign w_accept = w_scan_end && (w_match_next == MATCH_W'(DEBOUNCE_SCANS))
                     && (w_cand_next != r_stable);

   // ------------------------------------------------- scanner and debouncer
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_col_meta  <= 4'b1111;
         r_col_sync  <= 4'b1111;
         r_slot_cnt  <= '0;
         r_row_n     <= 4'b1110;
         r_row_idx   <= 2'd0;
         r_acc_cnt   <= 2'd0;
         r_acc_code  <= 4'h0;
         r_cand      <= NONE;
         r_stable    <= NONE;
         r_match     <= '0;
         r_key_code  <= 4'h0;
         r_key_valid <= 1'b0;
      end else begin
         r_col_meta  <= i_col_n;
         r_col_sync  <= r_col_meta;
         r_key_valid <= 1'b0;

         if (w_slot_end) begin
            r_slot_cnt <= '0;
            r_row_n    <= {r_row_n[2:0], r_row_n[3]};
            r_row_idx  <= r_row_idx + 2'd1;
            if (r_row_idx == 2'd3) begin
               r_acc_cnt  <= 2'd0;
               r_acc_code <= 4'h0;
            end else begin
               r_acc_cnt  <= w_tot_cnt;
               r_acc_code <= w_tot_code;
            end
         end else begin
            r_slot_cnt <= r_slot_cnt + CNT_W'(1);
         end

         if (w_scan_end) begin
            r_cand  <= w_cand_next;
            r_match <= w_match_next;
            if (w_accept) begin
               r_stable <= w_cand_next;
               // A debounced release updates the stable value silently.
               if (!w_cand_next[4]) begin
                  r_key_code  <= w_cand_next[3:0];
                  r_key_valid <= 1'b1;
               end
            end
         end
      end
   end

   // ------------------------------------------- coordinate entry FSM (next)
   always_comb begin
      w_state_next  = r_state;
      w_x_pend_next = r_x_pend;
      w_y_pend_next = r_y_pend;
      w_commit      = 1'b0;
      if (!i_enable) begin
         w_state_next = WAIT_X;
      end else if (r_state == WAIT_BAD) begin
         w_state_next = WAIT_X;
      end else if (r_key_valid) begin
         if (r_key_code == KEY_STAR) begin
            w_state_next = WAIT_X;
         end else begin
            case (r_state)
               WAIT_X: if (r_key_code <= 4'd9) begin
                  w_x_pend_next = r_key_code;
                  w_state_next  = WAIT_Y;
               end
               WAIT_Y: if (r_key_code <= 4'd9) begin
                  w_y_pend_next = r_key_code;
                  w_state_next  = WAIT_CONF;
               end
               WAIT_CONF: if (r_key_code == KEY_HASH) begin
                  w_commit     = 1'b1;
                  w_state_next = WAIT_X;
               end
               default: w_state_next = WAIT_X;
            endcase
         end
      end
   end

   // ------------------------------------------- coordinate entry FSM (state)
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state       <= WAIT_X;
         r_x_pend      <= 4'h0;
         r_y_pend      <= 4'h0;
         r_x           <= 4'h0;
         r_y           <= 4'h0;
         r_coord_valid <= 1'b0;
      end else begin
         r_state       <= w_state_next;
         r_x_pend      <= w_x_pend_next;
         r_y_pend      <= w_y_pend_next;
         r_coord_valid <= w_commit;
         if (w_commit) begin
            r_x <= r_x_pend;
            r_y <= r_y_pend;
         end
      end
   end

   assign o_row_n       = r_row_n;
   assign o_key_code    = r_key_code;
   assign o_key_valid   = r_key_valid;
   assign o_x           = r_x;
   assign o_y           = r_y;
   assign o_coord_valid = r_coord_valid;
   assign o_entry_state = r_state;

endmodule

// File: tb/tb_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_scanner
//
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=2
// (one full scan = 16 cycles). A small keypad model pulls a column low
// when its key is pressed and its row is driven low. Inputs change and
// outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_keypad_scanner;

   localparam int SCAN = 16;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic [3:0] col_n;
   logic [3:0] row_n;
   logic [3:0] key_code;
   logic       key_valid;
   logic [3:0] x;
   logic [3:0] y;
   logic       coord_valid;
   logic [1:0] entry_state;

   logic [15:0] pressed;   // bit r*4+c = key at row r, column c held down

   int n_checks = 0;
   int n_fails  = 0;
   int kv_count = 0;
   int cv_count = 0;

   keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2)) dut (
      .i_clk         (clk),
      .i_reset       (reset),
      .i_enable      (enable),
      .i_col_n       (col_n),
      .o_row_n       (row_n),
      .o_key_code    (key_code),
      .o_key_valid   (key_valid),
      .o_x           (x),
      .o_y           (y),
      .o_coord_valid (coord_valid),
      .o_entry_state (entry_state)
   );

   always #50 clk = ~clk;

   // Passive matrix: a pressed key connects its row line to its column line.
   always_comb begin
      col_n = 4'b1111;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (pressed[r*4+c] && !row_n[r]) col_n[c] = 1'b0;
   end

   always @(negedge clk) begin
      if (!reset && key_valid)   kv_count++;
      if (!reset && coord_valid) cv_count++;
   end

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Press at a scan boundary; the pulse lands one cycle after the 2nd scan.
   task automatic press_start(input int r, input int c, input logic [3:0] exp_code);
      pressed[r*4+c] = 1'b1;
      tick(2*SCAN - 1);
      check("key_valid_early", 8'(key_valid), 8'd0);
      tick(1);
      check("key_valid_pulse", 8'(key_valid), 8'd1);
      check("key_code", 8'(key_code), 8'(exp_code));
   endtask

   // Hold to the end of the 3rd scan, then release for 3 scans.
   task automatic finish_press(input int used);
      tick(SCAN - used);
      pressed = '0;
      tick(3*SCAN);
   endtask

   task automatic tap(input int r, input int c, input logic [3:0] exp_code);
      press_start(r, c, exp_code);
      finish_press(0);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_row_n"},       8'(row_n),       8'h0E);
      check({tag, "_key_code"},    8'(key_code),    8'h00);
      check({tag, "_key_valid"},   8'(key_valid),   8'h00);
      check({tag, "_x"},           8'(x),           8'h00);
      check({tag, "_y"},           8'(y),           8'h00);
      check({tag, "_coord_valid"}, 8'(coord_valid), 8'h00);
      check({tag, "_entry_state"}, 8'(entry_state), 8'h00);
   endtask

   initial begin
      logic [3:0] exp_row;
      reset   = 1'b1;
      enable  = 1'b1;
      pressed = '0;
      tick(3);
      check_reset_values("reset");
      reset = 1'b0;

      // Idle: rows step every 4 cycles, nothing else moves.
      for (int i = 1; i <= 64; i++) begin
         tick(1);
         exp_row = 4'b1111 ^ (4'b0001 << ((i / 4) % 4));
         check("row_n_idle", 8'(row_n), 8'(exp_row));
      end
      check("idle_kv_count", 8'(kv_count), 8'd0);
      check("idle_cv_count", 8'(cv_count), 8'd0);
      check("idle_state",    8'(entry_state), 8'd0);

      // '5' held for 3 scans: one pulse only, digit moves entry to WAIT_Y.
      tap(1, 1, 4'h5);
      check("held_5_kv_count", 8'(kv_count), 8'd1);
      check("state_after_5",   8'(entry_state), 8'd1);

      // '*' cancels back to WAIT_X.
      tap(3, 0, 4'hE);
      check("state_after_star", 8'(entry_state), 8'd0);

      // 3, 7, # commits x=3, y=7 one cycle after the '#' pulse.
      tap(0, 2, 4'h3);
      check("state_after_3", 8'(entry_state), 8'd1);
      tap(2, 0, 4'h7);
      check("state_after_7", 8'(entry_state), 8'd2);
      press_start(3, 2, 4'hF);
      check("cv_on_hash_pulse", 8'(coord_valid), 8'd0);
      tick(1);
      check("cv_after_hash", 8'(coord_valid), 8'd1);
      check("x_commit",      8'(x), 8'd3);
      check("y_commit",      8'(y), 8'd7);
      check("state_after_hash", 8'(entry_state), 8'd0);
      finish_press(1);
      check("cv_count_1", 8'(cv_count), 8'd1);

      // '2' then '*': cancel leaves x/y alone.
      tap(0, 1, 4'h2);
      check("state_after_2", 8'(entry_state), 8'd1);
      tap(3, 0, 4'hE);
      check("state_after_cancel", 8'(entry_state), 8'd0);
      check("x_kept", 8'(x), 8'd3);
      check("y_kept", 8'(y), 8'd7);
      check("cv_count_cancel", 8'(cv_count), 8'd1);

      // Chord '1' + '9' is rejected.
      pressed[0]  = 1'b1;
      pressed[10] = 1'b1;
      tick(3*SCAN);
      pressed = '0;
      tick(3*SCAN);
      check("chord_kv_count", 8'(kv_count), 8'd7);

      // '4' visible for a single scan only: not debounced.
      pressed[4] = 1'b1;
      tick(SCAN);
      pressed = '0;
      tick(3*SCAN);
      check("glitch_kv_count", 8'(kv_count), 8'd7);

      // Letter 'A' reports an event but does not move the FSM.
      tap(0, 3, 4'hA);
      check("state_after_A", 8'(entry_state), 8'd0);

      // Dropping enable in WAIT_Y forces WAIT_X; keys still report.
      tap(1, 2, 4'h6);
      check("state_after_6", 8'(entry_state), 8'd1);
      enable = 1'b0;
      tick(1);
      check("state_forced_x", 8'(entry_state), 8'd0);
      tick(SCAN - 1);
      tap(1, 0, 4'h4);
      check("state_disabled", 8'(entry_state), 8'd0);
      check("x_disabled",     8'(x), 8'd3);
      check("y_disabled",     8'(y), 8'd7);
      check("kv_count_disabled", 8'(kv_count), 8'd10);

      // Reset in WAIT_CONF, mid-scan, with a key held.
      enable = 1'b1;
      tap(2, 1, 4'h8);
      tap(2, 2, 4'h9);
      check("state_conf", 8'(entry_state), 8'd2);
      pressed[0] = 1'b1;
      tick(5);
      reset = 1'b1;
      tick(1);
      check_reset_values("midreset");
      tick(1);
      pressed = '0;
      reset   = 1'b0;
      tick(3*SCAN);
      check("post_reset_kv_count", 8'(kv_count), 8'd12);
      check("post_reset_cv_count", 8'(cv_count), 8'd1);
      check("post_reset_state",    8'(entry_state), 8'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Input-side counterpart to the 4-digit seven-segment driver.
- Drives a 4x4 matrix keypad one row at a time and reads the columns back.
- Debounces the scan result, reports one event per key press, and assembles two decimal digits into the desired x/y coordinate used in keyboard mode.
- Sits between the keypad pins and the top-level FSM/display. It runs on the same 10 MHz clock.

Parameters:
- SCAN_DIV, 10000: clock cycles per row slot (1 ms at 10 MHz). Must be >= 4.
- DEBOUNCE_SCANS, 4: consecutive identical full-scan results required before a result is accepted. Must be >= 1.

Ports:
- clk  in  1  10 MHz system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  high when the top FSM is in keyboard mode; gates coordinate entry only
- col_n  in  4  keypad column inputs, active low, pulled up externally, asynchronous
- row_n  out  4  keypad row drives, active low, one-hot-low
- key_code  out  4  code of the last accepted key
- key_valid  out  1  one-cycle pulse when a new key press is accepted
- x  out  4  committed x-coordinate, 0-9
- y  out  4  committed y-coordinate, 0-9
- coord_valid  out  1  one-cycle pulse when x/y are committed
- entry_state  out  2  coordinate-entry FSM state, for display

Behaviour:
- Reset values:
  - row_n = 4'b1110.
  - key_code, x, y = 0.
  - key_valid, coord_valid = 0.
  - entry_state = WAIT_X.
  - Column synchronizer = 4'b1111.
  - All counters = 0; debounce candidate and stable result = NONE.
- Synchronizer: col_n passes through a 2-FF synchronizer before any use.
- Row scanning:
  - A slot counter runs 0..SCAN_DIV-1, then wraps.
  - On wrap, the low bit of row_n rotates to the next row: row0 -> row1 -> row2 -> row3 -> row0.
  - The synchronized columns for the current row are sampled at slot count SCAN_DIV-1, before the row advances.
  - A full scan is 4*SCAN_DIV cycles, ending at the row3 sample.
- Key map, row r / column c, codes in hex:
  - r0: 1, 2, 3, A(0xA)
  - r1: 4, 5, 6, B(0xB)
  - r2: 7, 8, 9, C(0xC)
  - r3: *(0xE), 0(0x0), #(0xF), D(0xD)
- Scan result, evaluated at the end of each full scan:
  - Exactly one key low across all 4 samples: result is its code.
  - Zero keys, or two or more keys (ghost/chord rejection): result is NONE.
  - NONE is an internal 5th value and never appears on key_code.
- Debounce:
  - If result == candidate: match count increments, saturating at DEBOUNCE_SCANS.
  - Otherwise: candidate <= result and match count <= 1.
  - On the cycle match count reaches DEBOUNCE_SCANS with candidate != stable: stable <= candidate.
  - If that new stable value is not NONE: key_code <= candidate, and key_valid pulses on the next cycle.
- Event rules:
  - A held key never repeats.
  - Re-press needs a debounced NONE in between.
  - A direct change from K1 to K2 with no NONE between them reports K2.
  - A release produces no pulse.
- Coordinate entry FSM (entry_state encoding):
  - WAIT_X = 00: digit 0-9 -> x_pend <= code; go to WAIT_Y.
  - WAIT_Y = 01: digit -> y_pend <= code; go to WAIT_CONF.
  - WAIT_CONF = 10: '#' -> x <= x_pend, y <= y_pend, coord_valid pulses for 1 cycle; go to WAIT_X. Digits are ignored here.
  - Encoding 11 is unused; if reached, go to WAIT_X.
- Other FSM rules:
  - FSM transitions happen only on key_valid cycles.
  - '*' in any state cancels: go to WAIT_X; x and y are unchanged.
  - Letter keys A-D are ignored.
  - '#' in WAIT_X or WAIT_Y is ignored.
  - enable low: the FSM is forced to WAIT_X and key events are ignored. Scanning, debounce, key_code and key_valid keep operating. x and y hold their values.
- Latency: x, y and coord_valid update on the cycle after the '#' key_valid pulse.
- Reset mid-scan or mid-entry: everything returns to reset values on the next edge. No pulse is emitted during reset or on the cycle it releases.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=2, one scan = 16 cycles):
- After reset, hold col_n = 4'b1111 for 64 cycles:
  - row_n cycles 1110 -> 1101 -> 1011 -> 0111 every 4 cycles.
  - key_valid, coord_valid stay 0; x = y = 0; entry_state = 00.
- Press key '5' (col_n[1] low while row_n = 1101) for 3 scans:
  - Exactly one key_valid pulse, at the end of the 2nd scan plus 1 cycle, with key_code = 5.
  - No further pulse while the key is held.
- Press '3', release for 2 scans, press '7', release, press '#':
  - key_valid pulses with codes 3, 7, F.
  - entry_state goes 00 -> 01 -> 10 -> 00.
  - One cycle later: coord_valid = 1, x = 3, y = 7.
- Press '2', then '*':
  - entry_state goes 01 -> 00.
  - x/y keep their previous values (3/7); no coord_valid.
- Press '1' and '9' simultaneously (two columns low):
  - No key_valid.
  - Single-scan glitch on '4' (one scan only): no key_valid.
- enable = 0 and press '4':
  - key_valid pulses with key_code = 4.
  - entry_state stays 00.
  - Assert reset during WAIT_CONF: all outputs return to reset values.
